// File: rtl/div_seq.sv
// div_seq: restoring sequential divider, one quotient bit per clock, start/done handshake.
// Define DIV_SEQ_SIGNED_EN for two's-complement operands (adds a one-cycle sign FIX state).
module div_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
`ifdef DIV_SEQ_SIGNED_EN
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
`endif
  state_t           state;
  logic [WIDTH-1:0] p, q, d;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   sh;
  logic [WIDTH+1:0] sub;
  logic             ge;
  logic [WIDTH-1:0] p_nx, q_nx, dvd_in, dvs_in, rem_zero;
  assign sh   = {p, q[WIDTH-1]};
  assign sub  = {1'b0, sh} - {2'b0, d};
  assign ge   = ~sub[WIDTH+1];
  assign p_nx = ge ? sub[WIDTH-1:0] : sh[WIDTH-1:0];
  assign q_nx = {q[WIDTH-2:0], ge};
`ifdef DIV_SEQ_SIGNED_EN
  logic neg_q, neg_r;
  assign dvd_in   = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_in   = divisor[WIDTH-1] ? -divisor : divisor;
  // q still holds the dividend magnitude; re-apply its sign to report the raw dividend
  assign rem_zero = neg_r ? -q : q;
`else
  assign dvd_in   = dividend;
  assign dvs_in   = divisor;
  assign rem_zero = q;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      p           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef DIV_SEQ_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          q     <= dvd_in;
          d     <= dvs_in;
          p     <= '0;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= ITER;
`ifdef DIV_SEQ_SIGNED_EN
          neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_r <= dividend[WIDTH-1];
`endif
        end
        ITER: if (d == '0) begin
          quotient    <= '1;
          remainder   <= rem_zero;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
          state       <= DONE;
        end else begin
          p   <= p_nx;
          q   <= q_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            quotient  <= q_nx;
            remainder <= p_nx;
`ifdef DIV_SEQ_SIGNED_EN
            state     <= FIX;
`else
            done      <= 1'b1;
            state     <= DONE;
`endif
          end
        end
`ifdef DIV_SEQ_SIGNED_EN
        FIX: begin
          quotient  <= neg_q ? -quotient : quotient;
          remainder <= neg_r ? -remainder : remainder;
          done      <= 1'b1;
          state     <= DONE;
        end
`endif
        DONE: begin
          done        <= 1'b0;
          busy        <= 1'b0;
          div_by_zero <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: table-driven and hand-sequenced checks of div_seq with a result scoreboard.
module tb_div_seq;
  localparam int W = 8;
`ifdef DIV_SEQ_SIGNED_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = W;
`endif
  logic         clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic [W-1:0] quotient, remainder;
  logic         busy, done, div_by_zero;
  div_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {logic [W-1:0] a, b, q, r; logic z;} vec_t;
  typedef struct {logic [W-1:0] q, r; logic z; int acc;} exp_t;
  exp_t sb[$];
  exp_t cur;
  vec_t tv[8];
  int   checks = 0, errors = 0, acc;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // done must last one cycle, and every done must match a pending accepted operation
  always @(negedge clk) begin
    if (!reset && done) begin
      chk("done_width", int'(prev_done), 0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_done: done with no pending op at cycle %0d", cyc);
      end else begin
        cur = sb.pop_front();
        chk("quotient", int'(quotient), int'(cur.q));
        chk("remainder", int'(remainder), int'(cur.r));
        chk("div_by_zero", int'(div_by_zero), int'(cur.z));
        chk("latency", cyc - cur.acc, cur.z ? 1 : LAT);
      end
    end
    prev_done = done;
  end

  task automatic drain();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: busy=%0b pending=%0d", busy, sb.size());
      sb.delete();
    end
  endtask

  task automatic issue(input vec_t v, output int a);
    drain();
    start    = 1'b1;
    dividend = v.a;
    divisor  = v.b;
    a        = cyc + 1;
    sb.push_back('{v.q, v.r, v.z, a});
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  task automatic wait_cyc(input int c);
    int n = 0;
    while (cyc < c && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
`ifdef DIV_SEQ_SIGNED_EN
    tv[0] = '{8'hF9, 8'd2,   8'hFD, 8'hFF, 1'b0};
    tv[1] = '{8'h80, 8'hFF,  8'h80, 8'h00, 1'b0};
    tv[2] = '{8'd100, 8'd7,  8'd14, 8'd2,  1'b0};
    tv[3] = '{8'd7,  8'hFE,  8'hFD, 8'd1,  1'b0};
    tv[4] = '{8'hF9, 8'hFE,  8'd3,  8'hFF, 1'b0};
    tv[5] = '{8'd5,  8'd0,   8'hFF, 8'd5,  1'b1};
    tv[6] = '{8'hFB, 8'd0,   8'hFF, 8'hFB, 1'b1};
    tv[7] = '{8'd3,  8'd10,  8'd0,  8'd3,  1'b0};
`else
    tv[0] = '{8'd100, 8'd7,  8'd14, 8'd2,  1'b0};
    tv[1] = '{8'd5,   8'd0,  8'hFF, 8'd5,  1'b1};
    tv[2] = '{8'd3,   8'd10, 8'd0,  8'd3,  1'b0};
    tv[3] = '{8'd255, 8'd1,  8'd255, 8'd0, 1'b0};
    tv[4] = '{8'd200, 8'd13, 8'd15, 8'd5,  1'b0};
    tv[5] = '{8'd128, 8'd128, 8'd1, 8'd0,  1'b0};
    tv[6] = '{8'd0,   8'd5,  8'd0,  8'd0,  1'b0};
    tv[7] = '{8'd254, 8'd255, 8'd0, 8'd254, 1'b0};
`endif
    #12;
    chk("reset_quotient", int'(quotient), 0);
    chk("reset_remainder", int'(remainder), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      issue(tv[i], acc);
      drain();
    end
    // back-to-back with start held high: second op accepted on the first IDLE edge
    drain();
    start    = 1'b1;
    dividend = 8'd255;
    divisor  = 8'd1;
    acc      = cyc + 1;
    sb.push_back('{8'd255, 8'd0, 1'b0, acc});
    @(negedge clk);
    dividend = 8'd255;
    divisor  = 8'd255;
    sb.push_back('{8'd1, 8'd0, 1'b0, acc + LAT + 2});
    wait_cyc(acc + LAT + 2);
    start = 1'b0;
    drain();
    // start pulses while busy are ignored
    issue('{8'd100, 8'd7, 8'd14, 8'd2, 1'b0}, acc);
    wait_cyc(acc + 1);
    start = 1'b1; dividend = 8'd9; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(acc + 4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    // reset mid-operation
    issue('{8'd100, 8'd7, 8'd14, 8'd2, 1'b0}, acc);
    wait_cyc(acc + 3);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    sb.delete();
    chk("midrst_quotient", int'(quotient), 0);
    chk("midrst_remainder", int'(remainder), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_dbz", int'(div_by_zero), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue('{8'd50, 8'd6, 8'd8, 8'd2, 1'b0}, acc);
    drain();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
